// File: rtl/upc_seq.sv
// Move sequencer for the WIDTH-bit up/down counter: round-robin arbitration of two requesters,
// one count per falling clock edge toward a target. Define UPC_SEQ_SHORTEST_EN for wrap-around shortest-path moves.
module upc_seq #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             preclr,
    input  logic             req0,
    input  logic [WIDTH-1:0] tgt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] tgt1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             up_down,
    output logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] tgt_reg;
    logic             owner_reg;
    logic             last_reg;

    logic             winner;
    logic             any_req;
    logic             at_tgt;
    logic             dir_down;
    logic [WIDTH-1:0] q_next;
    logic [1:0]       gnt_vec;
    logic [1:0]       done_vec;

    // On a tie the requester that did not win last time goes next.
    assign any_req = req0 | req1;
    assign winner  = (req0 && req1) ? ~last_reg : req1;
    assign at_tgt  = (q_reg == tgt_reg);

`ifdef UPC_SEQ_SHORTEST_EN
    logic [WIDTH-1:0] dup;
    logic [WIDTH-1:0] half;
    assign dup      = tgt_reg - q_reg;
    assign half     = {1'b1, {(WIDTH-1){1'b0}}};
    assign dir_down = (dup > half);
`else
    assign dir_down = !(tgt_reg > q_reg);
`endif

    assign q_next = dir_down ? (q_reg - WIDTH'(1)) : (q_reg + WIDTH'(1));

    always_ff @(negedge clk or posedge preclr) begin
        if (preclr) begin
            state_reg <= ST_IDLE;
            q_reg     <= '0;
            tgt_reg   <= '0;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_reg <= winner;
                        last_reg  <= winner;
                        tgt_reg   <= winner ? tgt1 : tgt0;
                        state_reg <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (at_tgt) begin
                        state_reg <= ST_DONE;
                    end else begin
                        q_reg <= q_next;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-requester decode of ownership and completion.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_owner
            assign gnt_vec[gi]  = (state_reg != ST_IDLE) && (owner_reg == 1'(gi));
            assign done_vec[gi] = (state_reg == ST_DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign done0   = done_vec[0];
    assign done1   = done_vec[1];
    assign busy    = (state_reg != ST_IDLE);
    assign step    = (state_reg == ST_MOVE) && !at_tgt;
    assign up_down = step && dir_down;
    assign q       = q_reg;

endmodule

// File: tb/tb_upc_seq.sv
// Scoreboard bench for upc_seq: expected step/done events are queued per move and matched
// as the DUT produces them. Honours UPC_SEQ_SHORTEST_EN for the direction model.
module tb_upc_seq;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         preclr;
    logic         req0, req1;
    logic [W-1:0] tgt0, tgt1;
    logic         gnt0, gnt1, done0, done1, busy, up_down, step;
    logic [W-1:0] q;

    upc_seq #(.WIDTH(W)) dut (
        .clk(clk), .preclr(preclr),
        .req0(req0), .tgt0(tgt0), .req1(req1), .tgt1(tgt1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .up_down(up_down), .step(step), .q(q)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_done;
        bit           dir;
        logic [W-1:0] q_after;
        bit           owner;
        int           len;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           run_len = 0;
    logic [W-1:0] model_q;
    logic [W-1:0] pend_q;
    bit           pend_valid = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_down(input logic [W-1:0] cur, input logic [W-1:0] tgt);
`ifdef UPC_SEQ_SHORTEST_EN
        logic [W-1:0] d;
        d = tgt - cur;
        return (d > 3'd4);
`else
        return !(tgt > cur);
`endif
    endfunction

    task automatic push_move(input bit who, input logic [W-1:0] tgt);
        logic [W-1:0] cur;
        int           n;
        exp_t         e;
        cur = model_q;
        n = 0;
        while (cur != tgt && n < 16) begin
            e.is_done = 0;
            e.dir     = model_down(cur, tgt);
            cur       = e.dir ? cur - 3'd1 : cur + 3'd1;
            e.q_after = cur;
            e.owner   = who;
            e.len     = 0;
            sb.push_back(e);
            n++;
        end
        e.is_done = 1;
        e.dir     = 0;
        e.q_after = cur;
        e.owner   = who;
        e.len     = n + 2;
        sb.push_back(e);
        model_q = cur;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_move(input bit who, input logic [W-1:0] tgt);
        int start;
        bit got;
        push_move(who, tgt);
        start = done_cnt;
        tick();
        if (who) begin req1 = 1; tgt1 = tgt; end
        else     begin req0 = 1; tgt0 = tgt; end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = who ? gnt1 : gnt0;
        end
        check("grant_wait", 32'(got), 32'd1);
        req0 = 0;
        req1 = 0;
        // Later target changes must not affect the move in flight.
        tgt0 = ~tgt;
        tgt1 = ~tgt;
        for (int i = 0; i < 40 && done_cnt == start; i++) tick();
        check("done_wait", 32'(done_cnt - start), 32'd1);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {24'd0, gnt0, gnt1, done0, done1, busy, up_down, step, 1'b0} | 32'(q), 32'd0);
    endtask

    // Monitor: mid-cycle sampling, the DUT updates on falling edges.
    always @(posedge clk) begin
        exp_t e;
        if (preclr) begin
            pend_valid = 0;
            run_len = 0;
        end else begin
            if (pend_valid) begin
                check("q_step", 32'(q), 32'(pend_q));
                pend_valid = 0;
            end
            check("exclusive", 32'((gnt0 & gnt1) | (done0 & done1)), 32'd0);
            check("busy", 32'(busy), 32'(gnt0 | gnt1));
            run_len = busy ? run_len + 1 : 0;
            if (step) begin
                if (sb.size() == 0) begin
                    check("unexpected_step", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("step_kind", 32'(e.is_done), 32'd0);
                    check("up_down", 32'(up_down), 32'(e.dir));
                    check("step_owner", 32'(gnt1), 32'(e.owner));
                    pend_q = e.q_after;
                    pend_valid = 1;
                end
            end else begin
                check("up_down_idle", 32'(up_down), 32'd0);
            end
            if (done0 | done1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", 32'(e.is_done), 32'd1);
                    check("done_owner", 32'(done1), 32'(e.owner));
                    check("done_q", 32'(q), 32'(e.q_after));
                    check("gnt_len", 32'(run_len), 32'(e.len));
                end
                done_cnt++;
            end
        end
    end

    initial begin
        int start;
        preclr = 1; req0 = 0; req1 = 0; tgt0 = 0; tgt1 = 0;
        model_q = 0;
        #1;
        check_reset_outputs("reset_at_start");
        #20;
        preclr = 0;

        run_move(0, 3'd5);
        run_move(1, 3'd2);
        run_move(0, 3'd4);
        run_move(0, 3'd4);
        run_move(0, 3'd1);
        run_move(0, 3'd6);

        // Round-robin with both requesters held.
        tick();
        preclr = 1;
        #1;
        check_reset_outputs("reset_async");
        tick();
        preclr = 0;
        model_q = 0;
        push_move(0, 3'd3);
        push_move(1, 3'd1);
        push_move(0, 3'd3);
        start = done_cnt;
        req0 = 1; tgt0 = 3'd3;
        req1 = 1; tgt1 = 3'd1;
        for (int i = 0; i < 60 && done_cnt < start + 3; i++) tick();
        req0 = 0;
        req1 = 0;
        check("rr_done_count", 32'(done_cnt - start), 32'd3);
        repeat (3) tick();

        // Preclear in the middle of a move loses it without a done pulse.
        push_move(0, 3'd7);
        req0 = 1; tgt0 = 3'd7;
        repeat (3) tick();
        req0 = 0;
        tick();
        #2;
        preclr = 1;
        #1;
        check_reset_outputs("reset_mid_move");
        sb.delete();
        model_q = 0;
        tick();
        preclr = 0;
        start = done_cnt;
        repeat (6) tick();
        check("no_done_after_clr", 32'(done_cnt - start), 32'd0);
        check("q_after_clr", 32'(q), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/upc_seq.md
Name: upc_seq

Overview:
- Move sequencer for the team's WIDTH-bit up/down counter.
- Owns the counter register. Steps it one count per clock toward a requested target value.
- Shares the counter between two requesters with round-robin arbitration.
- Drives the counter-style up_down and step strobes so the datapath can follow each move.

Parameters:
WIDTH, 3, counter and target width in bits (2..8)

Ports:
clk  input  1  clock; all state updates on the falling edge, matching the counter family
preclr  input  1  asynchronous active-high preclear; async reset of all state
req0  input  1  requester 0 move request; hold high until gnt0
tgt0  input  WIDTH  requester 0 target value; sampled only on its grant edge
req1  input  1  requester 1 move request
tgt1  input  WIDTH  requester 1 target value
gnt0  output  1  requester 0 owns the counter (high in MOVE and DONE)
gnt1  output  1  requester 1 owns the counter
done0  output  1  one-cycle completion pulse for requester 0
done1  output  1  one-cycle completion pulse for requester 1
busy  output  1  high whenever state is not IDLE
up_down  output  1  step direction: 0 = up, 1 = down; 0 when not stepping
step  output  1  q changes at the next falling edge
q  output  WIDTH  current count

Behaviour:
- Reset (preclr=1, immediate, any state): q=0, state=IDLE, tgt_reg=0, owner=0, last=1. All outputs 0.
- States: IDLE, MOVE, DONE. Outputs are decoded from registered state, q and tgt_reg.
- IDLE transitions:
  - No request: stay in IDLE.
  - Single request: grant it.
  - Both requesting: grant the requester not equal to last. After reset, req0 wins the first tie.
  - Grant edge: owner<=winner, last<=winner, tgt_reg<=tgt_winner, state<=MOVE.
- MOVE, step generation:
  - If q != tgt_reg: step=1 and up_down=direction. At the falling edge, q<=q+1 (up) or q-1 (down), modulo 2^WIDTH.
  - If q == tgt_reg: step=0, and at the edge state<=DONE.
- DONE: done_owner=1 for exactly one cycle, then state<=IDLE.
- Direction (default): up if tgt_reg > q, unsigned compare; otherwise down. Never wraps.
- Latency: grant edge E. Distance d gives step=1 for d cycles, with q updates at E+1..E+d. DONE is entered at E+d+1, IDLE at E+d+2. A zero-distance move still spends one cycle in MOVE.
- Request rules:
  - req may drop after grant without aborting the move.
  - tgt changes after the grant edge are ignored.
  - A req still high when returning to IDLE re-arbitrates under round-robin, so the other requester wins if also requesting.
- Reset mid-move: q=0 immediately, no done pulse, the move is lost. The requester must re-request.
- gnt0/gnt1, done0/done1 are never both high at once. busy = gnt0|gnt1.

Optional Feature:
- Macro: UPC_SEQ_SHORTEST_EN.
- Defined:
  - Direction is chosen by modular distance: dup = (tgt_reg - q) mod 2^WIDTH.
  - Go up if dup <= 2^(WIDTH-1), else down. Tie goes up.
  - q wraps through 0 / 2^WIDTH-1. Distance is at most 2^(WIDTH-1).
- Undefined: plain compare rule; no wrap.
- Ports and state machine are identical in both builds.

Test Plan:
1. Reset: preclr pulse at any point -> q=0, all outputs 0 asynchronously, with no clock edge needed.
2. From reset, req0=1 tgt0=5 -> gnt0 for 7 cycles, step=1 up_down=0 for 5 cycles, q=1,2,3,4,5, then done0 one cycle, busy drops.
3. q=5, req1=1 tgt1=2 -> up_down=1 for 3 steps, q=4,3,2, done1 one cycle, done0 stays 0.
4. After reset, req0=req1=1 held, tgt0=3 tgt1=1 -> order is req0 (q 0→3), req1 (q 3→1), then req0 again (q=1→3); never two consecutive grants to one requester while both request.
5. q=4, req0 tgt0=4 -> no step, gnt0 for 2 cycles, done0 pulse, q stays 4.
6. WIDTH=3, q=1, tgt0=6:
   - With UPC_SEQ_SHORTEST_EN -> 3 down steps, q=0,7,6.
   - Without -> 5 up steps, q=2..6.
   - Separately, preclr asserted mid-move -> q=0, no done pulse.
